// File: rtl/krz_pkg.sv
// Shared types and defaults for the KRZ GPIO peripherals.
// The event record is what the event FIFO carries, head first on the pop port.
package krz_pkg;

    localparam int N_PINS = 16;
    localparam int PIN_W  = 4;
    localparam int TS_W   = 16;

    typedef struct packed {
        logic [PIN_W-1:0] pin;
        logic             rise;
        logic [TS_W-1:0]  ts;
    } krz_evt_t;

    localparam int EVT_W = $bits(krz_evt_t);

endpackage

// File: rtl/krz_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push is ignored when full, pop when empty.
// Handshake: an entry moves when the producer asserts push while not full, or the consumer asserts pop while not empty.
module krz_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign count     = r_wr_ptr - r_rd_ptr;
    // Head reads as zero while empty so the outputs are clean straight out of reset.
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/krz_gpio_event.sv
// Per-pin edge capture into single-entry pending slots, drained lowest-pin-first into the event FIFO.
// Pop handshake: the head entry leaves at the edge where evt_valid && evt_ready.
module krz_gpio_event
    import krz_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PINS-1:0]      gpio_read,
    input  logic [N_PINS-1:0]      rise_en,
    input  logic [N_PINS-1:0]      fall_en,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [PIN_W-1:0]       evt_pin,
    output logic                   evt_rise,
    output logic [TS_W-1:0]        evt_ts,
    output logic [$clog2(DEPTH):0] evt_count,
    output logic                   irq,
    output logic                   ovf,
    input  logic                   ovf_clr
);

    logic [TS_W-1:0]   r_ts;
    logic [N_PINS-1:0] r_prev;
    logic              r_primed;
    logic [N_PINS-1:0] r_slot_vld;
    logic [N_PINS-1:0] r_slot_rise;
    logic [TS_W-1:0]   r_slot_ts [N_PINS];
    logic              r_ovf;

    logic [N_PINS-1:0] w_rise;
    logic [N_PINS-1:0] w_fall;
    logic [N_PINS-1:0] w_edge;
    logic [N_PINS-1:0] w_grant;
    logic [N_PINS-1:0] w_drop;
    logic [PIN_W-1:0]  w_sel;
    logic              w_sel_vld;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    krz_evt_t          w_push_evt;
    krz_evt_t          w_head_evt;

    // No edges until prev holds a real sample, so reset never fakes a transition.
    assign w_rise = r_primed ? (gpio_read & ~r_prev & rise_en) : '0;
    assign w_fall = r_primed ? (~gpio_read & r_prev & fall_en) : '0;
    assign w_edge = w_rise | w_fall;

    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int i = N_PINS - 1; i >= 0; i--) begin
            if (r_slot_vld[i]) begin
                w_sel     = PIN_W'(i);
                w_sel_vld = 1'b1;
            end
        end
    end

    assign w_push = w_sel_vld && !w_full;

    always_comb begin
        w_grant = '0;
        if (w_push) w_grant[w_sel] = 1'b1;
    end

    // A slot being drained this cycle can take a new edge; any other occupied slot loses it.
    assign w_drop = w_edge & r_slot_vld & ~w_grant;

    always_comb begin
        w_push_evt.pin  = w_sel;
        w_push_evt.rise = r_slot_rise[w_sel];
        w_push_evt.ts   = r_slot_ts[w_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts        <= '0;
            r_prev      <= '0;
            r_primed    <= 1'b0;
            r_slot_vld  <= '0;
            r_slot_rise <= '0;
            r_ovf       <= 1'b0;
            for (int i = 0; i < N_PINS; i++) r_slot_ts[i] <= '0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_prev   <= gpio_read;
            r_primed <= 1'b1;
            for (int i = 0; i < N_PINS; i++) begin
                if (w_edge[i] && !w_drop[i]) begin
                    r_slot_vld[i]  <= 1'b1;
                    r_slot_rise[i] <= w_rise[i];
                    r_slot_ts[i]   <= r_ts;
                end else if (w_grant[i]) begin
                    r_slot_vld[i]  <= 1'b0;
                end
            end
            if (|w_drop)      r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    krz_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_evt),
        .pop       (evt_ready),
        .pop_data  (w_head_evt),
        .full      (w_full),
        .empty     (w_empty),
        .count     (evt_count)
    );

    assign evt_valid = !w_empty;
    assign irq       = !w_empty;
    assign evt_pin   = w_head_evt.pin;
    assign evt_rise  = w_head_evt.rise;
    assign evt_ts    = w_head_evt.ts;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_krz_gpio_event.sv
// Directed bench for krz_gpio_event: a queue-based event model checked against the DUT every cycle,
// plus literal expectations for the primed rule, latency, ordering, overflow, wrap and reset.
module tb_krz_gpio_event;

  bit          clk;
  logic        rst;
  logic [15:0] gpio_read;
  logic [15:0] rise_en;
  logic [15:0] fall_en;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_pin;
  logic        evt_rise;
  logic [15:0] evt_ts;
  logic [3:0]  evt_count;
  logic        irq;
  logic        ovf;
  logic        ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  krz_gpio_event #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_read (gpio_read),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pin   (evt_pin),
    .evt_rise  (evt_rise),
    .evt_ts    (evt_ts),
    .evt_count (evt_count),
    .irq       (irq),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: event queue {pin, rise, ts}, one pending record per pin.
  logic [15:0] m_ts;
  logic [15:0] m_prev;
  logic        m_primed;
  logic        m_ovf;
  logic        m_pv [16];
  logic        m_pr [16];
  logic [15:0] m_pt [16];
  logic [20:0] exp_q[$];
  logic [20:0] pop_log[$];

  always @(posedge clk) begin
    int          sel;
    logic        drop;
    logic        r;
    logic        f;
    logic [20:0] push_e;
    bit          full0;
    if (rst) begin
      m_ts = '0; m_prev = '0; m_primed = 1'b0; m_ovf = 1'b0;
      for (int i = 0; i < 16; i++) begin m_pv[i] = 1'b0; m_pr[i] = 1'b0; m_pt[i] = '0; end
      exp_q.delete();
    end else begin
      full0 = (exp_q.size() == 8);
      sel = -1;
      push_e = '0;
      if (!full0)
        for (int i = 0; i < 16; i++) if (m_pv[i] && sel < 0) sel = i;
      if (sel >= 0) push_e = {4'(sel), m_pr[sel], m_pt[sel]};
      drop = 1'b0;
      for (int i = 0; i < 16; i++) begin
        r = m_primed && gpio_read[i] && !m_prev[i] && rise_en[i];
        f = m_primed && !gpio_read[i] && m_prev[i] && fall_en[i];
        if (r || f) begin
          if (m_pv[i] && i != sel) drop = 1'b1;
          else begin m_pv[i] = 1'b1; m_pr[i] = r; m_pt[i] = m_ts; end
        end else if (i == sel) begin
          m_pv[i] = 1'b0;
        end
      end
      if (exp_q.size() != 0 && evt_ready) pop_log.push_back(exp_q.pop_front());
      if (sel >= 0) exp_q.push_back(push_e);
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_prev = gpio_read;
      m_primed = 1'b1;
      m_ts = m_ts + 16'd1;
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
    chk("irq", 32'(irq), 32'(exp_q.size() != 0));
    chk("evt_count", 32'(evt_count), 32'(exp_q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (exp_q.size() != 0) begin
      chk("evt_pin", 32'(evt_pin), 32'(exp_q[0][20:17]));
      chk("evt_rise", 32'(evt_rise), 32'(exp_q[0][16]));
      chk("evt_ts", 32'(evt_ts), 32'(exp_q[0][15:0]));
    end
  end

  // driver
  initial begin
    int wraps;
    rst = 1'b1; gpio_read = '0; rise_en = '0; fall_en = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_count", 32'(evt_count), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pin", 32'(evt_pin), 32'd0);
    chk("rst_ts", 32'(evt_ts), 32'd0);

    // primed rule: all-ones right out of reset is not a rising edge
    rst = 1'b0; gpio_read = 16'hFFFF; rise_en = 16'hFFFF;
    tick(4);
    chk("prime_count", 32'(evt_count), 32'd0);
    chk("prime_valid", 32'(evt_valid), 32'd0);
    chk("prime_ovf", 32'(ovf), 32'd0);

    // single rising edge on pin 0: slot at k+1 (ts 6), visible at k+2
    gpio_read = 16'h0000;
    tick(2);
    rise_en = 16'h0001; gpio_read = 16'h0001;
    tick(1);
    chk("lat_k1_valid", 32'(evt_valid), 32'd0);
    tick(1);
    chk("lat_k2_valid", 32'(evt_valid), 32'd1);
    chk("lat_pin", 32'(evt_pin), 32'd0);
    chk("lat_rise", 32'(evt_rise), 32'd1);
    chk("lat_ts", 32'(evt_ts), 32'd6);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("pop_irq", 32'(irq), 32'd0);
    chk("pop_count", 32'(evt_count), 32'd0);

    // sixteen simultaneous rising edges, loaded with ts 11
    gpio_read = 16'h0000;
    tick(2);
    rise_en = 16'hFFFF; fall_en = 16'hFFFF; gpio_read = 16'hFFFF;
    tick(1);
    chk("burst_k1_count", 32'(evt_count), 32'd0);
    tick(8);
    chk("burst_full_count", 32'(evt_count), 32'd8);
    chk("burst_head_pin", 32'(evt_pin), 32'd0);
    tick(2);
    chk("burst_hold_count", 32'(evt_count), 32'd8);

    // pin 9 falls while its slot is still pending behind a full FIFO
    gpio_read = 16'hFDFF;
    tick(1);
    chk("drop_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);

    pop_log.delete();
    evt_ready = 1'b1;
    tick(20);
    evt_ready = 1'b0;
    chk("drain_count", 32'(evt_count), 32'd0);
    chk("drain_ovf", 32'(ovf), 32'd0);
    chk("drain_n", 32'(pop_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < pop_log.size(); i++) begin
      chk("drain_pin", 32'(pop_log[i][20:17]), 32'(i));
      chk("drain_rise", 32'(pop_log[i][16]), 32'd1);
      chk("drain_ts", 32'(pop_log[i][15:0]), 32'd11);
    end

    // pin 3 toggling, rising only, across the timestamp wrap
    rise_en = '0; fall_en = '0; gpio_read = '0;
    tick(2);
    while (m_ts != 16'd65500) @(negedge clk);
    rise_en = 16'h0008;
    pop_log.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      gpio_read = gpio_read ^ 16'h0008;
      tick(2);
    end
    tick(4);
    evt_ready = 1'b0;
    chk("wrap_n", 32'(pop_log.size()), 32'd16);
    wraps = 0;
    for (int i = 0; i < pop_log.size(); i++) begin
      chk("wrap_pin", 32'(pop_log[i][20:17]), 32'd3);
      chk("wrap_rise", 32'(pop_log[i][16]), 32'd1);
      if (i > 0) begin
        chk("wrap_ts_step", 32'(16'(pop_log[i][15:0] - pop_log[i-1][15:0])), 32'd4);
        if (pop_log[i][15:0] < pop_log[i-1][15:0]) wraps++;
      end
    end
    chk("wrap_seen", 32'(wraps), 32'd1);

    // reset with five events queued
    gpio_read = '0; rise_en = '0;
    tick(2);
    rise_en = 16'h001F; gpio_read = 16'h001F;
    tick(6);
    chk("pre_rst_count", 32'(evt_count), 32'd5);
    rst = 1'b1;
    tick(1);
    chk("post_rst_valid", 32'(evt_valid), 32'd0);
    chk("post_rst_count", 32'(evt_count), 32'd0);
    rst = 1'b0;
    tick(1);
    chk("reprime_count1", 32'(evt_count), 32'd0);
    tick(3);
    chk("reprime_count4", 32'(evt_count), 32'd0);
    chk("reprime_valid", 32'(evt_valid), 32'd0);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/krz_gpio_event.md
# krz_gpio_event

Edge-event capture stage downstream of the KRZ GPIO debouncer. It takes the 16 debounced, stable pin levels and detects rising and falling edges per pin, gated by per-pin enables. Each edge is timestamped and queued in a small event FIFO that software drains through a valid/ready pop port. The block also raises a level interrupt while events are queued, and a sticky overflow flag when events are lost.

## Interface
- N_PINS, 16, number of debounced inputs; pin index width is clog2(N_PINS) = 4
- DEPTH, 8, event FIFO entries; must be a power of two ≥ 2
- TS_W, 16, timestamp counter width
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- gpio_read  in  N_PINS  debounced pin levels from the debouncer
- rise_en  in  N_PINS  per-pin rising-edge capture enable
- fall_en  in  N_PINS  per-pin falling-edge capture enable
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready
- evt_pin  out  4  head event pin index
- evt_rise  out  1  head event edge type: 1 = rising, 0 = falling
- evt_ts  out  TS_W  head event timestamp
- evt_count  out  clog2(DEPTH)+1  current FIFO occupancy
- irq  out  1  equals evt_valid
- ovf  out  1  sticky flag: an event was dropped
- ovf_clr  in  1  clears ovf; a new drop in the same cycle wins

## Operation
- Reset values: all outputs 0; FIFO empty; all pending slots empty; ts counter 0; primed = 0.
- ts counter: free-running, +1 every cycle, wraps 2^TS_W−1 → 0.
- prev register: updated every cycle with gpio_read.
- On the first cycle after reset, primed is 0: prev loads, primed sets, and no edges are detected.
- Edge detect, per pin i, when primed:
  - rise = gpio_read[i] & ~prev[i] & rise_en[i]
  - fall = ~gpio_read[i] & prev[i] & fall_en[i]
- Pending slot, one per pin, holding {valid, rise, ts}: a detected edge loads the slot with the current ts counter value.
- If an edge is detected on a pin whose slot is still valid and is not being drained this cycle, the new edge is dropped and ovf is set. The original slot is kept.
- Arbiter: when the FIFO is not full at the start of the cycle, it selects the lowest-index valid slot, pushes {pin, rise, ts} into the FIFO, and clears that slot. At most one push per cycle.
- A slot drained in cycle c may be reloaded by an edge detected in the same cycle c.
- Deasserting an enable does not clear an existing pending slot.
- FIFO:
  - Pop when evt_valid && evt_ready; outputs show the head entry.
  - Push and pop in the same cycle are both allowed unless the FIFO was full, in which case only the pop happens.
  - Pointers are clog2(DEPTH) bits plus a wrap bit.
  - evt_count updates in the same edge as push/pop.
- A full FIFO never drops events directly. Slots hold their events; loss happens only through the slot-overflow rule above.

## Timing
- gpio_read changes after edge k:
  - edge k+1: slot loaded, with ts = counter value at edge k+1
  - edge k+2: event pushed; evt_valid/irq high from edge k+2
- Pop: the head advances at the edge where evt_valid && evt_ready; the next entry is visible in the following cycle.
- K simultaneous edges drain over K consecutive cycles in ascending pin order, given FIFO space.
- rst asserted mid-operation: the next edge returns all state to reset values, queued events are discarded, and the primed sequence restarts.
- ovf_clr and a drop in the same cycle: ovf = 1.

## Structure
- Shared package krz_pkg:
  - event struct type {pin[3:0], rise, ts[TS_W-1:0]}
  - N_PINS and TS_W defaults
- One sub-module, krz_fifo: a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/count. It is reusable by other KRZ peripherals.
- The top level holds edge detect, the pending slots, and the fixed-priority arbiter.

## Test plan
- Reset then hold gpio_read = 16'hFFFF: no events, evt_count = 0, ovf = 0. Confirms the primed rule.
- rise_en = 16'h0001, pin 0 goes 0→1 at edge k:
  - evt_valid high from edge k+2
  - evt_pin = 0, evt_rise = 1, evt_ts = ts at edge k+1
  - pop clears irq
- All 16 enables set, all pins rise together:
  - 16 pushes over 16 cycles in order pin 0..15
  - after 8 pushes the FIFO is full and pins 8–15 stay pending
  - popping continuously drains all 16 with no ovf
- FIFO full and pin 9 still pending, pin 9 toggles again with fall_en set: the new edge is dropped, ovf = 1. Asserting ovf_clr with no further drop clears it.
- Toggle pin 3 with rise_en[3] = 1 and fall_en[3] = 0: only rising events are queued. Timestamps are strictly increasing modulo 2^16, including across a counter wrap.
- Assert rst with 5 events queued: one edge later evt_valid = 0, evt_count = 0, and no event is produced in the first cycle after reset.
